// File: rtl/c3po_dispatch.sv
// c3po_dispatch: routes wide ingress beats to one of PORTS_P egress ports and
// serialises each beat into OUT_BYTES_P-byte chunks under per-port backpressure.
//
// Ports:
//   sig_clock, sig_reset_L         clock, async active-low reset
//   sig_val/sop/eop/vbc/id/data    ingress beat (byte 0 at LSB)
//   sig_in_ready                   beat accepted when sig_val & sig_in_ready
//   sig_o_val/sop/eop/vbc/data     per-port chunk stream
//   sig_o_ready                    per-port downstream ready
//   sig_cnt0_val / sig_cnt1_val    per-port packet / byte counters
//   sig_drop_cnt                   count of accepted illegal beats

// Per-port lane: one-beat holding register, chunk index and IDLE/SEND FSM.
//   load/ld_*   beat to capture (only asserted by the top while idle)
//   idle        lane can take a beat
//   o_*         chunk outputs, zero while idle
//   cnt0/cnt1   packets / bytes transferred
module c3po_dispatch_port #(
  parameter int CNT_SIZE_P  = 8,
  parameter int IN_BYTES_P  = 160,
  parameter int OUT_BYTES_P = 32,
  parameter int CNT_SAT_P   = 0
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [IN_BYTES_P*8-1:0]  ld_data,
  input  logic [7:0]               ld_vbc,
  input  logic                     ld_sop,
  input  logic                     ld_eop,
  input  logic                     o_ready,
  output logic                     idle,
  output logic                     o_val,
  output logic                     o_sop,
  output logic                     o_eop,
  output logic [7:0]               o_vbc,
  output logic [OUT_BYTES_P*8-1:0] o_data,
  output logic [CNT_SIZE_P-1:0]    cnt0,
  output logic [CNT_SIZE_P-1:0]    cnt1
);
  localparam int NCH = IN_BYTES_P / OUT_BYTES_P;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  // Adder is wide enough for both the counter and an 8-bit increment.
  localparam int SW  = ((CNT_SIZE_P > 8) ? CNT_SIZE_P : 8) + 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e                               state_q, state_d;
  logic [KW-1:0]                        k_q, k_d;
  logic [NCH-1:0][OUT_BYTES_P*8-1:0]    data_q, data_d;
  logic [7:0]                           vbc_q, vbc_d;
  logic                                 sop_q, sop_d, eop_q, eop_d;
  logic [CNT_SIZE_P-1:0]                cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic [15:0]                          off, rem;
  logic                                 last;
  logic [7:0]                           chunk_vbc;
  logic [OUT_BYTES_P*8-1:0]             chunk;

  function automatic logic [CNT_SIZE_P-1:0] cnt_add(input logic [CNT_SIZE_P-1:0] a,
                                                    input logic [7:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (CNT_SAT_P != 0 && s > SW'({CNT_SIZE_P{1'b1}})) cnt_add = '1;
    else                                               cnt_add = s[CNT_SIZE_P-1:0];
  endfunction

  // Current chunk: remaining bytes decide its size and whether it is the last.
  always_comb begin
    off       = 16'(k_q) * 16'(OUT_BYTES_P);
    rem       = 16'(vbc_q) - off;
    last      = (rem <= 16'(OUT_BYTES_P));
    chunk_vbc = last ? rem[7:0] : 8'(OUT_BYTES_P);
    chunk     = data_q[k_q];
    for (int b = 0; b < OUT_BYTES_P; b++)
      if (8'(b) >= chunk_vbc) chunk[b*8 +: 8] = '0;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    data_d  = data_q;
    vbc_d   = vbc_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    case (state_q)
      IDLE: if (load) begin
        state_d = SEND;
        k_d     = '0;
        data_d  = ld_data;
        vbc_d   = ld_vbc;
        sop_d   = ld_sop;
        eop_d   = ld_eop;
      end
      SEND: if (o_ready) begin
        if (last) state_d = IDLE;
        else      k_d     = k_q + KW'(1);
        cnt1_d = cnt_add(cnt1_q, chunk_vbc);
        if (eop_q && last) cnt0_d = cnt_add(cnt0_q, 8'd1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      data_q  <= '0;
      vbc_q   <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      data_q  <= data_d;
      vbc_q   <= vbc_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign idle   = (state_q == IDLE);
  assign o_val  = (state_q == SEND);
  assign o_sop  = o_val & sop_q & (k_q == '0);
  assign o_eop  = o_val & eop_q & last;
  assign o_vbc  = o_val ? chunk_vbc : 8'd0;
  assign o_data = o_val ? chunk : '0;
  assign cnt0   = cnt0_q;
  assign cnt1   = cnt1_q;
endmodule

module c3po_dispatch #(
  parameter int PORTS_P     = 4,
  parameter int CNT_SIZE_P  = 8,
  parameter int IN_BYTES_P  = 160,
  parameter int OUT_BYTES_P = 32,
  parameter int CNT_SAT_P   = 0
)(
  input  logic                                   sig_clock,
  input  logic                                   sig_reset_L,
  input  logic                                   sig_val,
  input  logic                                   sig_sop,
  input  logic                                   sig_eop,
  input  logic [7:0]                             sig_vbc,
  input  logic [3:0]                             sig_id,
  input  logic [IN_BYTES_P*8-1:0]                sig_data,
  output logic                                   sig_in_ready,
  output logic [PORTS_P-1:0]                     sig_o_val,
  output logic [PORTS_P-1:0]                     sig_o_sop,
  output logic [PORTS_P-1:0]                     sig_o_eop,
  output logic [PORTS_P-1:0][7:0]                sig_o_vbc,
  output logic [PORTS_P-1:0][OUT_BYTES_P*8-1:0]  sig_o_data,
  input  logic [PORTS_P-1:0]                     sig_o_ready,
  output logic [PORTS_P-1:0][CNT_SIZE_P-1:0]     sig_cnt0_val,
  output logic [PORTS_P-1:0][CNT_SIZE_P-1:0]     sig_cnt1_val,
  output logic [CNT_SIZE_P-1:0]                  sig_drop_cnt
);
  logic [PORTS_P-1:0]    port_idle, load;
  logic                  legal, tgt_idle;
  logic [CNT_SIZE_P:0]   drop_sum;
  logic [CNT_SIZE_P-1:0] drop_q, drop_d;

  // Ready depends only on the beat header and lane state, never on o_ready.
  always_comb begin
    legal    = ({1'b0, sig_id} < 5'(PORTS_P)) && (sig_vbc != 8'd0) &&
               (sig_vbc <= 8'(IN_BYTES_P));
    tgt_idle = 1'b0;
    for (int p = 0; p < PORTS_P; p++)
      if (sig_id == 4'(p)) tgt_idle = port_idle[p];
    sig_in_ready = sig_reset_L & (legal ? tgt_idle : 1'b1);
    for (int p = 0; p < PORTS_P; p++)
      load[p] = sig_val & legal & (sig_id == 4'(p)) & port_idle[p];
  end

  // Illegal beats are swallowed and counted.
  always_comb begin
    drop_sum = {1'b0, drop_q} + {{CNT_SIZE_P{1'b0}}, 1'b1};
    drop_d   = drop_q;
    if (sig_val && sig_in_ready && !legal)
      drop_d = (CNT_SAT_P != 0 && drop_sum[CNT_SIZE_P]) ? {CNT_SIZE_P{1'b1}}
                                                         : drop_sum[CNT_SIZE_P-1:0];
  end

  always_ff @(posedge sig_clock or negedge sig_reset_L) begin
    if (!sig_reset_L) drop_q <= '0;
    else              drop_q <= drop_d;
  end

  assign sig_drop_cnt = drop_q;

  for (genvar p = 0; p < PORTS_P; p++) begin : g_port
    c3po_dispatch_port #(
      .CNT_SIZE_P (CNT_SIZE_P),
      .IN_BYTES_P (IN_BYTES_P),
      .OUT_BYTES_P(OUT_BYTES_P),
      .CNT_SAT_P  (CNT_SAT_P)
    ) u_port (
      .clk    (sig_clock),
      .rst_n  (sig_reset_L),
      .load   (load[p]),
      .ld_data(sig_data),
      .ld_vbc (sig_vbc),
      .ld_sop (sig_sop),
      .ld_eop (sig_eop),
      .o_ready(sig_o_ready[p]),
      .idle   (port_idle[p]),
      .o_val  (sig_o_val[p]),
      .o_sop  (sig_o_sop[p]),
      .o_eop  (sig_o_eop[p]),
      .o_vbc  (sig_o_vbc[p]),
      .o_data (sig_o_data[p]),
      .cnt0   (sig_cnt0_val[p]),
      .cnt1   (sig_cnt1_val[p])
    );
  end
endmodule

// File: tb/tb_c3po_dispatch.sv
// Bench for c3po_dispatch: two instances (wrap and saturate counters) share one
// stimulus; a queue-of-chunks model per port predicts every output each cycle.
module tb_c3po_dispatch;
  localparam int PORTS = 4, CNT = 8, INB = 160, OUTB = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic sig_val, sig_sop, sig_eop;
  logic [7:0] sig_vbc;
  logic [3:0] sig_id;
  logic [INB*8-1:0] sig_data;
  logic [PORTS-1:0] sig_o_ready;

  logic in_rdy_w, in_rdy_s;
  logic [PORTS-1:0] val_w, sop_w, eop_w, val_s, sop_s, eop_s;
  logic [PORTS-1:0][7:0] vbc_w, vbc_s;
  logic [PORTS-1:0][OUTB*8-1:0] data_w, data_s;
  logic [PORTS-1:0][CNT-1:0] c0_w, c1_w, c0_s, c1_s;
  logic [CNT-1:0] drop_w, drop_s;

  always #5 clk = ~clk;

  c3po_dispatch #(.PORTS_P(PORTS), .CNT_SIZE_P(CNT), .IN_BYTES_P(INB),
                  .OUT_BYTES_P(OUTB), .CNT_SAT_P(0)) u_wrap (
    .sig_clock(clk), .sig_reset_L(rst_n), .sig_val(sig_val), .sig_sop(sig_sop),
    .sig_eop(sig_eop), .sig_vbc(sig_vbc), .sig_id(sig_id), .sig_data(sig_data),
    .sig_in_ready(in_rdy_w), .sig_o_val(val_w), .sig_o_sop(sop_w), .sig_o_eop(eop_w),
    .sig_o_vbc(vbc_w), .sig_o_data(data_w), .sig_o_ready(sig_o_ready),
    .sig_cnt0_val(c0_w), .sig_cnt1_val(c1_w), .sig_drop_cnt(drop_w));

  c3po_dispatch #(.PORTS_P(PORTS), .CNT_SIZE_P(CNT), .IN_BYTES_P(INB),
                  .OUT_BYTES_P(OUTB), .CNT_SAT_P(1)) u_sat (
    .sig_clock(clk), .sig_reset_L(rst_n), .sig_val(sig_val), .sig_sop(sig_sop),
    .sig_eop(sig_eop), .sig_vbc(sig_vbc), .sig_id(sig_id), .sig_data(sig_data),
    .sig_in_ready(in_rdy_s), .sig_o_val(val_s), .sig_o_sop(sop_s), .sig_o_eop(eop_s),
    .sig_o_vbc(vbc_s), .sig_o_data(data_s), .sig_o_ready(sig_o_ready),
    .sig_cnt0_val(c0_s), .sig_cnt1_val(c1_s), .sig_drop_cnt(drop_s));

  typedef struct {
    logic [255:0] data;
    int           vbc;
    bit           sop;
    bit           eop;
  } chunk_t;

  chunk_t q[PORTS][$];
  int tot_pk[PORTS], tot_by[PORTS], tot_drop;
  int checks = 0, errors = 0;
  logic last_in_rdy;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int wrapv(input int t);
    return t % (1 << CNT);
  endfunction

  function automatic int satv(input int t);
    return (t > (1 << CNT) - 1) ? (1 << CNT) - 1 : t;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < PORTS; p++) begin
      q[p].delete();
      tot_pk[p] = 0;
      tot_by[p] = 0;
    end
    tot_drop = 0;
  endtask

  // Everything must read zero while reset is held.
  task automatic chk_reset_state();
    chk("rst_in_ready", 256'(in_rdy_w), 256'(0));
    chk("rst_drop", 256'(drop_w), 256'(0));
    for (int p = 0; p < PORTS; p++) begin
      chk($sformatf("rst_val[%0d]", p), 256'(val_w[p] | sop_w[p] | eop_w[p]), 256'(0));
      chk($sformatf("rst_vbc[%0d]", p), 256'(vbc_w[p]), 256'(0));
      chk($sformatf("rst_data[%0d]", p), 256'(data_w[p]), 256'(0));
      chk($sformatf("rst_cnt[%0d]", p), 256'({c0_w[p], c1_w[p], c0_s[p], c1_s[p]}), 256'(0));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_reset_state();
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock: drive, check everything against the model, advance the model.
  task automatic cycle(input logic v, input logic [3:0] id, input logic [7:0] vbc,
                       input logic sp, input logic ep, input logic [PORTS-1:0] rdy);
    bit legal, exp_rdy;
    int n, cv;
    chunk_t c;
    sig_val = v; sig_id = id; sig_vbc = vbc; sig_sop = sp; sig_eop = ep;
    sig_o_ready = rdy;
    for (int w = 0; w < INB / 4; w++) sig_data[w*32 +: 32] = $urandom;
    #3;
    legal   = (int'(id) < PORTS) && (vbc >= 8'd1) && (int'(vbc) <= INB);
    exp_rdy = legal ? (q[int'(id)].size() == 0) : 1'b1;
    last_in_rdy = in_rdy_w;
    chk("in_ready", 256'(in_rdy_w), 256'(exp_rdy));
    chk("in_ready_sat", 256'(in_rdy_s), 256'(exp_rdy));
    for (int p = 0; p < PORTS; p++) begin
      chk($sformatf("o_val[%0d]", p), 256'(val_w[p]), 256'(q[p].size() != 0));
      if (q[p].size() != 0) begin
        c = q[p][0];
        chk($sformatf("o_data[%0d]", p), 256'(data_w[p]), c.data);
        chk($sformatf("o_vbc[%0d]", p), 256'(vbc_w[p]), 256'(c.vbc));
        chk($sformatf("o_sop[%0d]", p), 256'(sop_w[p]), 256'(c.sop));
        chk($sformatf("o_eop[%0d]", p), 256'(eop_w[p]), 256'(c.eop));
      end else begin
        chk($sformatf("idle_out[%0d]", p), 256'({data_w[p], vbc_w[p], sop_w[p], eop_w[p]}), 256'(0));
      end
      chk($sformatf("cnt0w[%0d]", p), 256'(c0_w[p]), 256'(wrapv(tot_pk[p])));
      chk($sformatf("cnt1w[%0d]", p), 256'(c1_w[p]), 256'(wrapv(tot_by[p])));
      chk($sformatf("cnt0s[%0d]", p), 256'(c0_s[p]), 256'(satv(tot_pk[p])));
      chk($sformatf("cnt1s[%0d]", p), 256'(c1_s[p]), 256'(satv(tot_by[p])));
    end
    chk("drop_w", 256'(drop_w), 256'(wrapv(tot_drop)));
    chk("drop_s", 256'(drop_s), 256'(satv(tot_drop)));
    // transfers at this edge
    for (int p = 0; p < PORTS; p++)
      if (q[p].size() != 0 && rdy[p]) begin
        c = q[p].pop_front();
        tot_by[p] += c.vbc;
        if (c.eop) tot_pk[p]++;
      end
    // acceptance at this edge
    if (v && exp_rdy) begin
      if (!legal) tot_drop++;
      else begin
        n = (int'(vbc) + OUTB - 1) / OUTB;
        for (int k = 0; k < n; k++) begin
          cv = int'(vbc) - k * OUTB;
          if (cv > OUTB) cv = OUTB;
          c.vbc  = cv;
          c.data = '0;
          for (int b = 0; b < cv; b++) c.data[b*8 +: 8] = sig_data[(k*OUTB + b)*8 +: 8];
          c.sop = sp && (k == 0);
          c.eop = ep && (k == n - 1);
          q[int'(id)].push_back(c);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, '1);
  endtask

  initial begin
    logic [7:0] edges [7];
    logic [7:0] vbc;
    logic [3:0] id;
    logic [PORTS-1:0] rdy;
    int r;
    edges = '{8'd1, 8'd31, 8'd32, 8'd33, 8'd64, 8'd159, 8'd160};

    rst_n = 1'b0; sig_val = 1'b0; sig_sop = 1'b0; sig_eop = 1'b0;
    sig_vbc = '0; sig_id = '0; sig_data = '0; sig_o_ready = '0;
    #2;
    chk_reset_state();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full-width beat to port 0: five 32-byte chunks.
    cycle(1'b1, 4'd0, 8'd160, 1'b1, 1'b1, '1);
    idle_cycles(5);
    chk("dir_cnt0_p0", 256'(c0_w[0]), 256'(1));
    chk("dir_cnt1_p0", 256'(c1_w[0]), 256'(160));

    // Second beat: 320 bytes wraps to 64, saturates at 255.
    cycle(1'b1, 4'd0, 8'd160, 1'b1, 1'b1, '1);
    idle_cycles(5);
    chk("dir_wrap_cnt1", 256'(c1_w[0]), 256'(64));
    chk("dir_sat_cnt1", 256'(c1_s[0]), 256'(255));
    chk("dir_cnt0_2", 256'(c0_w[0]), 256'(2));

    // Short tail chunk.
    cycle(1'b1, 4'd2, 8'd70, 1'b1, 1'b1, '1);
    idle_cycles(3);
    chk("dir_cnt1_p2", 256'(c1_w[2]), 256'(70));

    // Port 1 stalled while port 3 runs.
    cycle(1'b1, 4'd1, 8'd100, 1'b1, 1'b0, 4'b1101);
    cycle(1'b1, 4'd1, 8'd50, 1'b0, 1'b1, 4'b1101);
    chk("busy_in_rdy_p1", 256'(last_in_rdy), 256'(0));
    cycle(1'b1, 4'd3, 8'd64, 1'b1, 1'b1, 4'b1101);
    chk("free_in_rdy_p3", 256'(last_in_rdy), 256'(1));
    cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'b1101);
    idle_cycles(6);

    // Illegal beats.
    cycle(1'b1, 4'd5, 8'd10, 1'b1, 1'b1, '1);
    cycle(1'b1, 4'd0, 8'd0, 1'b1, 1'b1, '1);
    cycle(1'b1, 4'd0, 8'd200, 1'b1, 1'b1, '1);
    chk("dir_drop", 256'(drop_w), 256'(3));

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0)      vbc = 8'd0;
      else if (r == 1) vbc = 8'($urandom_range(161, 255));
      else if (r < 5)  vbc = edges[$urandom_range(0, 6)];
      else             vbc = 8'($urandom_range(1, 160));
      id = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      for (int p = 0; p < PORTS; p++) rdy[p] = ($urandom_range(0, 3) != 0);
      cycle(1'($urandom_range(0, 9) < 7), id, vbc, 1'($urandom), 1'($urandom), rdy);
    end
    idle_cycles(12);

    // Reset while chunk 2 of a five-chunk beat is on the wire.
    cycle(1'b1, 4'd0, 8'd160, 1'b1, 1'b1, '1);
    idle_cycles(2);
    chk("pre_rst_val", 256'(val_w[0]), 256'(1));
    do_reset();
    cycle(1'b1, 4'd0, 8'd160, 1'b1, 1'b1, '1);
    idle_cycles(5);
    chk("post_rst_cnt1", 256'(c1_w[0]), 256'(160));
    chk("post_rst_cnt0", 256'(c0_w[0]), 256'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/c3po_dispatch.md
# c3po_dispatch

Parametrised packet dispatcher and width converter. It accepts one wide beat per cycle (up to IN_BYTES_P bytes, tagged with a destination id), routes it to one of PORTS_P output ports, and serialises it into OUT_BYTES_P-byte chunks under per-port backpressure. It keeps per-port packet and byte counters with selectable wrap or saturate behaviour, and counts dropped beats. It sits between the wide ingress stream and the per-port narrow egress logic.

## Interface
- PORTS_P, 4, number of output ports (1..16).
- CNT_SIZE_P, 8, width of every counter.
- IN_BYTES_P, 160, input beat width in bytes (≤255).
- OUT_BYTES_P, 32, output chunk width in bytes; divides IN_BYTES_P.
- CNT_SAT_P, 0, counter mode: 0 = wrap modulo 2^CNT_SIZE_P, 1 = saturate at all-ones.

Ports:
- sig_clock  in  1  single clock; all logic rising-edge.
- sig_reset_L  in  1  asynchronous active-low reset.
- sig_val  in  1  input beat valid.
- sig_sop / sig_eop  in  1 each  beat starts / ends a packet.
- sig_vbc  in  8  valid byte count of beat.
- sig_id  in  4  destination port.
- sig_data  in  IN_BYTES_P*8  beat payload; byte 0 at LSB.
- sig_in_ready  out  1  beat accepted at this edge when sig_val & sig_in_ready.
- sig_o_val / sig_o_sop / sig_o_eop  out  [PORTS_P]  per-port chunk valid / first / last.
- sig_o_vbc  out  [PORTS_P][8]  valid bytes in chunk.
- sig_o_data  out  [PORTS_P][OUT_BYTES_P*8]  chunk payload.
- sig_o_ready  in  [PORTS_P]  downstream accepts chunk.
- sig_cnt0_val  out  [PORTS_P][CNT_SIZE_P]  packets completed per port.
- sig_cnt1_val  out  [PORTS_P][CNT_SIZE_P]  bytes transferred per port.
- sig_drop_cnt  out  CNT_SIZE_P  beats dropped.

## Operation
- Legal beat: sig_id < PORTS_P and 1 ≤ sig_vbc ≤ IN_BYTES_P. Any other beat is illegal.
- sig_in_ready = 0 while reset is asserted. Otherwise, for a legal beat, it is 1 when the target port is IDLE; for an illegal beat it is always 1. It is combinational from sig_id, sig_vbc and the port state.
- Each port has a one-beat holding register (data, vbc, sop, eop), a chunk index k and a two-state FSM:
  - IDLE: on accept, load the register, set k=0, go to SEND.
  - SEND: present chunk k. On sig_o_val & sig_o_ready: if it is the last chunk, go to IDLE; otherwise k+1.
- Number of chunks N = ceil(vbc/OUT_BYTES_P).
- Chunk k fields:
  - sig_o_data = bytes [k*OUT_BYTES_P +: OUT_BYTES_P], with bytes at or above sig_o_vbc forced to 0.
  - sig_o_vbc = min(OUT_BYTES_P, vbc − k*OUT_BYTES_P).
  - sig_o_sop = stored sop & (k==0).
  - sig_o_eop = stored eop & (k==N−1).
- sig_o_val = (state==SEND). All chunk outputs hold stable while sig_o_val & !sig_o_ready.
- In IDLE, sig_o_val/sop/eop/vbc/data are 0.
- Counters update on each transfer (val & ready) of a port:
  - cnt1 += sig_o_vbc.
  - cnt0 += 1 if sig_o_eop.
- sig_drop_cnt += 1 on each accepted illegal beat. Illegal beats produce no output.
- Counter arithmetic: add at CNT_SIZE_P+1 bits, then either truncate (wrap) or clamp to 2^CNT_SIZE_P−1 (saturate), per CNT_SAT_P.
- Packet framing (sop/eop pairing) is not checked; flags pass through as given.

## Timing
- Reset (async assert, sync-released use): all FSMs IDLE, all outputs 0, all counters 0.
- Reset mid-packet discards the held beat and any unsent chunks.
- Latency: a beat accepted at edge T gives chunk 0 valid in the cycle after T. With sig_o_ready held high, chunk k is valid in cycle T+1+k.
- The port returns to IDLE at the edge that transfers its last chunk, so it can accept a new beat one cycle later. Per-port throughput is one beat per N+1 cycles; different ports run concurrently.
- There is no combinational path from sig_o_ready to sig_in_ready.
- Counter outputs are registered and reflect transfers up to the previous edge.

## Test plan
- Reset, then beat id=0, vbc=160, sop=eop=1, sig_o_ready=1 → 5 chunks on port 0 in cycles T+1..T+5, vbc=32 each; sop on the first, eop on the fifth; cnt0=1, cnt1=160.
- Beat id=2, vbc=70 → 3 chunks with vbc 32, 32, 6; bytes 6..31 of the last chunk are 0; cnt1[2]=70.
- Port 1 busy with sig_o_ready=0 for 4 cycles → chunk 0 held stable; sig_in_ready=0 for id=1 but 1 for id=3, and port 3 proceeds in parallel.
- Beats with id=5 (PORTS_P=4), vbc=0, or vbc=200 → accepted, no output, sig_drop_cnt=3.
- CNT_SAT_P=0: two beats of vbc=160 to port 0 → cnt1=320 mod 256 = 64. CNT_SAT_P=1, same stimulus → cnt1=255.
- Assert reset during chunk 2 of a 5-chunk beat → outputs 0 immediately; after release, a fresh beat is serialised from chunk 0.
